spi_mem_frontend: RTL

SPI-slave command front end that sits directly upstream of `storage_controller`. It deserialises host SPI frames (opcode, address, data) in the `clk` domain and turns them into single-word SRAM read/write requests on a req/ack handshake. It also serialises read data back on MISO, with address auto-increment for bursts while CS is held low.

---
 rtl/spi_mem_frontend.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_frontend.sv
// Purpose : SPI mode-0 slave front end turning host frames into single-word SRAM read/write requests.
// Latency : pins -> detected edge 3 clk; mem_req rises 1 clk after the detected final address/data bit.
// Backpr. : mem_req holds until mem_ack; a request needed while one is pending is dropped and flags err.
// Ports   : spi_sclk/spi_cs_n/spi_mosi in, spi_miso out (SPI, async to clk);
//           mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in (req/ack to storage controller);
//           busy (frame active or request outstanding), err (sticky, cleared on next CS fall).
module spi_mem_frontend #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_IGNORE
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    // [0] first sync stage, [1] second stage, [2] previous value for edge detect
    logic [2:0]        sclk_sync_q, sclk_sync_d;
    logic [2:0]        cs_sync_q, cs_sync_d;
    logic [2:0]        mosi_sync_q, mosi_sync_d;
    logic              sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic              cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
    state_t            state_q, state_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] shift_in_q, shift_in_d;
    logic              op_read_q, op_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] miso_sh_q, miso_sh_d;
    logic              load_pend_q, load_pend_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
    logic              rdata_vld_q, rdata_vld_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] shift_next;
    logic [15:0]       addr16;
    logic [ADDR_W-1:0] addr_inc;
    logic [5:0]        phase_last;
    logic              phase_done;
    logic              issue, issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic              pending;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[1:0], spi_mosi};
        sclk_rise_d =  sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall_d = ~sclk_sync_q[1] &  sclk_sync_q[2];
        cs_rise_d   =  cs_sync_q[1] & ~cs_sync_q[2];
        cs_fall_d   = ~cs_sync_q[1] &  cs_sync_q[2];
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        op_read_d    = op_read_q;
        addr_d       = addr_q;
        miso_sh_d    = miso_sh_q;
        load_pend_d  = load_pend_q;
        rdata_hold_d = rdata_hold_q;
        rdata_vld_d  = rdata_vld_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = err_q;
        issue        = 1'b0;
        issue_we     = 1'b0;
        issue_addr   = addr_q;

        // mosi_sync_q[2] lines up with the registered rise pulse
        shift_next = {shift_in_q, mosi_sync_q[2]};
        addr16     = shift_next[15:0];
        addr_inc   = addr_q + ADDR_W'(1);

        case (state_q)
            S_CMD, S_DUMMY: phase_last = 6'd7;
            S_ADDR:         phase_last = 6'd15;
            default:        phase_last = 6'd31;
        endcase
        phase_done = (bit_cnt_q == phase_last);

        if (cs_fall_q) err_d = 1'b0;

        if (cs_rise_q) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            miso_sh_d   = '0;
            load_pend_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            if (cs_fall_q) begin
                state_d    = S_CMD;
                bit_cnt_d  = '0;
                shift_in_d = '0;
            end
        end else if (state_q != S_IGNORE && sclk_rise_q) begin
            shift_in_d = shift_next[DATA_W-2:0];
            bit_cnt_d  = bit_cnt_q + 6'd1;
            if (phase_done) begin
                bit_cnt_d  = '0;
                shift_in_d = '0;
                case (state_q)
                    S_CMD: begin
                        if (shift_next[7:0] == OP_WRITE || shift_next[7:0] == OP_READ) begin
                            state_d   = S_ADDR;
                            op_read_d = (shift_next[7:0] == OP_READ);
                        end else begin
                            state_d = S_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                    S_ADDR: begin
                        addr_d = addr16[ADDR_W-1:0];
                        if (op_read_q) begin
                            state_d    = S_DUMMY;
                            issue      = 1'b1;
                            issue_addr = addr16[ADDR_W-1:0];
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        issue    = 1'b1;
                        issue_we = 1'b1;
                        addr_d   = addr_inc;
                    end
                    S_DUMMY: begin
                        state_d     = S_RDATA;
                        miso_sh_d   = '0;
                        load_pend_d = 1'b1;
                    end
                    default: begin
                        // word boundary in RDATA: prefetch the word that loads at the next fall
                        addr_d      = addr_inc;
                        issue       = 1'b1;
                        issue_addr  = addr_inc;
                        load_pend_d = 1'b1;
                    end
                endcase
            end
        end else if (state_q == S_RDATA && sclk_fall_q) begin
            if (load_pend_q) begin
                load_pend_d = 1'b0;
                rdata_vld_d = 1'b0;
                miso_sh_d   = rdata_vld_q ? rdata_hold_q : '0;
                if (!rdata_vld_q) err_d = 1'b1;
            end else begin
                miso_sh_d = {miso_sh_q[DATA_W-2:0], 1'b0};
            end
        end

        pending = mem_req_q & ~mem_ack;
        if (mem_req_q && mem_ack) begin
            mem_req_d = 1'b0;
            if (!mem_we_q) begin
                rdata_hold_d = mem_rdata;
                rdata_vld_d  = 1'b1;
            end
        end

        if (issue) begin
            if (pending) begin
                err_d = 1'b1;
            end else begin
                mem_req_d  = 1'b1;
                mem_we_d   = issue_we;
                mem_addr_d = issue_addr;
                if (issue_we) mem_wdata_d = shift_next;
                else          rdata_vld_d = 1'b0;   // hold must reflect this read, not an older one
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b111;
            mosi_sync_q  <= 3'b000;
            sclk_rise_q  <= 1'b0;
            sclk_fall_q  <= 1'b0;
            cs_rise_q    <= 1'b0;
            cs_fall_q    <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_in_q   <= '0;
            op_read_q    <= 1'b0;
            addr_q       <= '0;
            miso_sh_q    <= '0;
            load_pend_q  <= 1'b0;
            rdata_hold_q <= '0;
            rdata_vld_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_rise_q  <= sclk_rise_d;
            sclk_fall_q  <= sclk_fall_d;
            cs_rise_q    <= cs_rise_d;
            cs_fall_q    <= cs_fall_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            op_read_q    <= op_read_d;
            addr_q       <= addr_d;
            miso_sh_q    <= miso_sh_d;
            load_pend_q  <= load_pend_d;
            rdata_hold_q <= rdata_hold_d;
            rdata_vld_q  <= rdata_vld_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
        end
    end

    assign spi_miso  = (state_q == S_RDATA) & miso_sh_q[DATA_W-1];
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE) | mem_req_q;
    assign err       = err_q;
endmodule
